// File: rtl/dm_sba_ctrl.sv
// RISC-V Debug Module System Bus Access controller: SBCS/SBADDRESS0/SBDATA0 plus a single-outstanding bus master.
// Optional WAIT-state response timeout is enabled by defining SBA_TIMEOUT_EN.
module dm_sba_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_wr_en,
    input  logic        csr_rd_en,
    input  logic [7:0]  csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        sb_req_vld,
    input  logic        sb_req_rdy,
    output logic        sb_req_wr,
    output logic [31:0] sb_req_addr,
    output logic [31:0] sb_req_wdata,
    output logic [2:0]  sb_req_size,
    input  logic        sb_rsp_vld,
    input  logic        sb_rsp_err,
    input  logic [31:0] sb_rsp_rdata
);

    localparam logic [7:0] ADDR_SBCS   = 8'h38;
    localparam logic [7:0] ADDR_SBADR0 = 8'h39;
    localparam logic [7:0] ADDR_SBDAT0 = 8'h3C;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        busyerr_q, busyerr_d;
    logic        rdonaddr_q, rdonaddr_d;
    logic [2:0]  access_q, access_d;
    logic        autoinc_q, autoinc_d;
    logic        rdondata_q, rdondata_d;
    logic [2:0]  sberr_q, sberr_d;
    logic [31:0] sbaddr_q, sbaddr_d;
    logic [31:0] sbdata_q, sbdata_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [2:0]  req_size_q, req_size_d;
    logic        req_wr_q, req_wr_d;

    logic        wr_sbcs, wr_adr0, wr_dat0, rd_dat0;
    logic        busy, can_start, trig_rd, trig_wr, misaligned, tmo_hit;
    logic [31:0] trig_addr, rsp_mask;

    assign wr_sbcs   = csr_wr_en && (csr_addr == ADDR_SBCS);
    assign wr_adr0   = csr_wr_en && (csr_addr == ADDR_SBADR0);
    assign wr_dat0   = csr_wr_en && (csr_addr == ADDR_SBDAT0);
    assign rd_dat0   = csr_rd_en && (csr_addr == ADDR_SBDAT0);
    assign busy      = (state_q != S_IDLE);
    assign can_start = !busy && (sberr_q == 3'd0) && !busyerr_q;
    assign trig_wr   = can_start && wr_dat0;
    assign trig_rd   = can_start && ((wr_adr0 && rdonaddr_q) || (rd_dat0 && rdondata_q && !wr_dat0));
    // A read-on-address trigger targets the address being written this cycle.
    assign trig_addr = wr_adr0 ? csr_wdata : sbaddr_q;

    always_comb begin
        case (access_q)
            3'd1:    misaligned = trig_addr[0];
            3'd2:    misaligned = |trig_addr[1:0];
            default: misaligned = 1'b0;
        endcase
        case (req_size_q)
            3'd0:    rsp_mask = 32'h0000_00FF;
            3'd1:    rsp_mask = 32'h0000_FFFF;
            default: rsp_mask = 32'hFFFF_FFFF;
        endcase
    end

`ifdef SBA_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = '0;
        tmo_hit   = 1'b0;
        if (state_q == S_WAIT && !sb_rsp_vld) begin
            if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) tmo_hit   = 1'b1;
            else                                         tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so no path infers a latch.
        state_d     = state_q;
        busyerr_d   = busyerr_q;
        rdonaddr_d  = rdonaddr_q;
        access_d    = access_q;
        autoinc_d   = autoinc_q;
        rdondata_d  = rdondata_q;
        sberr_d     = sberr_q;
        sbaddr_d    = sbaddr_q;
        sbdata_d    = sbdata_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_size_d  = req_size_q;
        req_wr_d    = req_wr_q;

        if (wr_sbcs) begin
            rdonaddr_d = csr_wdata[20];
            access_d   = csr_wdata[19:17];
            autoinc_d  = csr_wdata[16];
            rdondata_d = csr_wdata[15];
            busyerr_d  = busyerr_q & ~csr_wdata[22];
            sberr_d    = sberr_q & ~csr_wdata[14:12];
        end

        if (busy) begin
            if (wr_adr0 || wr_dat0 || rd_dat0) busyerr_d = 1'b1;
        end else begin
            if (wr_adr0) sbaddr_d = csr_wdata;
            if (wr_dat0) sbdata_d = csr_wdata;
        end

        if (trig_rd || trig_wr) begin
            if (access_q > 3'd2) begin
                sberr_d = 3'd4;
            end else if (misaligned) begin
                sberr_d = 3'd3;
            end else begin
                state_d     = S_REQ;
                req_addr_d  = trig_addr;
                req_wr_d    = trig_wr;
                req_wdata_d = trig_wr ? csr_wdata : 32'd0;
                req_size_d  = access_q;
            end
        end

        // Bus-side error updates come last so they win over a same-cycle W1C.
        case (state_q)
            S_REQ: if (sb_req_rdy) state_d = S_WAIT;
            S_WAIT: begin
                if (sb_rsp_vld) begin
                    state_d = S_IDLE;
                    if (sb_rsp_err) begin
                        sberr_d = 3'd2;
                    end else begin
                        if (!req_wr_q) sbdata_d = sb_rsp_rdata & rsp_mask;
                        if (autoinc_q) sbaddr_d = sbaddr_q + (32'd1 << req_size_q);
                    end
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                    sberr_d = 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busyerr_q   <= 1'b0;
            rdonaddr_q  <= 1'b0;
            access_q    <= 3'd2;
            autoinc_q   <= 1'b0;
            rdondata_q  <= 1'b0;
            sberr_q     <= 3'd0;
            sbaddr_q    <= 32'd0;
            sbdata_q    <= 32'd0;
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            req_size_q  <= 3'd0;
            req_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            busyerr_q   <= busyerr_d;
            rdonaddr_q  <= rdonaddr_d;
            access_q    <= access_d;
            autoinc_q   <= autoinc_d;
            rdondata_q  <= rdondata_d;
            sberr_q     <= sberr_d;
            sbaddr_q    <= sbaddr_d;
            sbdata_q    <= sbdata_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_size_q  <= req_size_d;
            req_wr_q    <= req_wr_d;
        end
    end

    always_comb begin
        csr_rdata = 32'd0;
        case (csr_addr)
            ADDR_SBCS:   csr_rdata = {3'd1, 6'd0, busyerr_q, busy, rdonaddr_q, access_q,
                                      autoinc_q, rdondata_q, sberr_q, 7'd32, 5'b00111};
            ADDR_SBADR0: csr_rdata = sbaddr_q;
            ADDR_SBDAT0: csr_rdata = sbdata_q;
            default:     csr_rdata = 32'd0;
        endcase
    end

    assign sb_req_vld   = (state_q == S_REQ);
    assign sb_req_wr    = req_wr_q;
    assign sb_req_addr  = req_addr_q;
    assign sb_req_wdata = req_wdata_q;
    assign sb_req_size  = req_size_q;

endmodule

// File: tb/tb_dm_sba_ctrl.sv
// Self-checking bench for dm_sba_ctrl: directed scenarios plus randomized CSR traffic against a transaction-level model.
module tb_dm_sba_ctrl;

    localparam int unsigned TMO = 256;
    localparam logic [7:0] A_SBCS  = 8'h38;
    localparam logic [7:0] A_ADDR0 = 8'h39;
    localparam logic [7:0] A_DATA0 = 8'h3C;
    localparam logic [31:0] SBCS_RESET = 32'h2004_0407;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_wr_en = 1'b0;
    logic        csr_rd_en = 1'b0;
    logic [7:0]  csr_addr = 8'd0;
    logic [31:0] csr_wdata = 32'd0;
    logic [31:0] csr_rdata;
    logic        sb_req_vld;
    logic        sb_req_rdy = 1'b0;
    logic        sb_req_wr;
    logic [31:0] sb_req_addr;
    logic [31:0] sb_req_wdata;
    logic [2:0]  sb_req_size;
    logic        sb_rsp_vld = 1'b0;
    logic        sb_rsp_err = 1'b0;
    logic [31:0] sb_rsp_rdata = 32'd0;

    dm_sba_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csr_wr_en    (csr_wr_en),
        .csr_rd_en    (csr_rd_en),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .sb_req_vld   (sb_req_vld),
        .sb_req_rdy   (sb_req_rdy),
        .sb_req_wr    (sb_req_wr),
        .sb_req_addr  (sb_req_addr),
        .sb_req_wdata (sb_req_wdata),
        .sb_req_size  (sb_req_size),
        .sb_rsp_vld   (sb_rsp_vld),
        .sb_rsp_err   (sb_rsp_err),
        .sb_rsp_rdata (sb_rsp_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural register contents, valid whenever the controller is idle.
    logic        m_busyerr, m_rdonaddr, m_autoinc, m_rdondata;
    logic [2:0]  m_access, m_err;
    logic [31:0] m_addr, m_data;

    // Bus responder behaviour for the next transfer.
    int          bus_rdy_dly = 0;
    int          bus_rsp_dly = 0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    task automatic model_reset();
        m_busyerr = 1'b0; m_rdonaddr = 1'b0; m_autoinc = 1'b0; m_rdondata = 1'b0;
        m_access = 3'd2; m_err = 3'd0; m_addr = 32'd0; m_data = 32'd0;
    endtask

    function automatic logic [31:0] exp_sbcs();
        return {3'd1, 6'd0, m_busyerr, 1'b0, m_rdonaddr, m_access, m_autoinc, m_rdondata,
                m_err, 7'd32, 5'b00111};
    endfunction

    function automatic logic [31:0] size_mask(input logic [2:0] acc);
        if (acc == 3'd0) return 32'h0000_00FF;
        if (acc == 3'd1) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    // All CSR tasks start and end on a falling edge.
    task automatic csr_write(input logic [7:0] a, input logic [31:0] d);
        csr_wr_en = 1'b1; csr_addr = a; csr_wdata = d;
        @(negedge clk);
        csr_wr_en = 1'b0; csr_wdata = $urandom;
    endtask

    task automatic csr_read(input logic [7:0] a, output logic [31:0] v);
        csr_rd_en = 1'b1; csr_addr = a;
        #1 v = csr_rdata;
        @(negedge clk);
        csr_rd_en = 1'b0;
    endtask

    task automatic serve(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        int waited = 0;
        while (!sb_req_vld && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("req_vld", 32'(sb_req_vld), 32'd1);
        if (!sb_req_vld) return;
        check("req_addr", sb_req_addr, addr);
        check("req_wr", 32'(sb_req_wr), 32'(wr));
        check("req_size", 32'(sb_req_size), 32'(m_access));
        if (wr) check("req_wdata", sb_req_wdata, wd);
        repeat (bus_rdy_dly) @(negedge clk);
        check("req_hold_addr", sb_req_addr, addr);
        check("req_hold_vld", 32'(sb_req_vld), 32'd1);
        sb_req_rdy = 1'b1;
        @(negedge clk);
        sb_req_rdy = 1'b0;
        check("req_drop", 32'(sb_req_vld), 32'd0);
        repeat (bus_rsp_dly) @(negedge clk);
        sb_rsp_vld = 1'b1; sb_rsp_err = bus_err; sb_rsp_rdata = bus_rdata;
        @(negedge clk);
        sb_rsp_vld = 1'b0; sb_rsp_err = 1'b0; sb_rsp_rdata = $urandom;
        if (bus_err) begin
            m_err = 3'd2;
        end else begin
            if (!wr) m_data = bus_rdata & size_mask(m_access);
            if (m_autoinc) m_addr = m_addr + (32'd1 << m_access);
        end
    endtask

    // A trigger just happened: predict whether it errors out or produces a bus transfer.
    task automatic attempt(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        if (m_err != 3'd0 || m_busyerr) begin
            check("no_op_blocked", 32'(sb_req_vld), 32'd0);
        end else if (m_access > 3'd2) begin
            m_err = 3'd4;
            check("no_op_badsize", 32'(sb_req_vld), 32'd0);
        end else if (addr % (32'd1 << m_access) != 32'd0) begin
            m_err = 3'd3;
            check("no_op_misalign", 32'(sb_req_vld), 32'd0);
        end else begin
            serve(wr, addr, wd);
        end
    endtask

    task automatic do_csr_wr(input logic [7:0] a, input logic [31:0] d);
        logic        do_op = 1'b0;
        logic        op_wr = 1'b0;
        logic [31:0] op_addr = m_addr;
        case (a)
            A_SBCS: begin
                m_rdonaddr = d[20]; m_access = d[19:17]; m_autoinc = d[16]; m_rdondata = d[15];
                if (d[22]) m_busyerr = 1'b0;
                m_err = m_err & ~d[14:12];
            end
            A_ADDR0: begin
                m_addr = d;
                if (m_rdonaddr) begin do_op = 1'b1; op_addr = d; end
            end
            A_DATA0: begin
                m_data = d; do_op = 1'b1; op_wr = 1'b1;
            end
            default: ;
        endcase
        csr_write(a, d);
        if (do_op) attempt(op_wr, op_addr, d);
    endtask

    task automatic do_csr_rd(input logic [7:0] a, output logic [31:0] v);
        logic [31:0] e;
        case (a)
            A_SBCS:  e = exp_sbcs();
            A_ADDR0: e = m_addr;
            A_DATA0: e = m_data;
            default: e = 32'd0;
        endcase
        csr_read(a, v);
        check($sformatf("csr_rd_%02h", a), v, e);
        if (a == A_DATA0 && m_rdondata) attempt(1'b0, m_addr, 32'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] d;
        logic [31:0] saved;
        logic [7:0]  a;
        int          cyc;
        logic        still_busy;

        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        csr_read(A_SBCS, v);
        check("rst_sbcs", v, SBCS_RESET);
        check("rst_req_vld", 32'(sb_req_vld), 32'd0);
        check("rst_req_addr", sb_req_addr, 32'd0);
        check("rst_req_wdata", sb_req_wdata, 32'd0);
        check("rst_req_size_wr", {28'd0, sb_req_size, sb_req_wr}, 32'd0);
        do_csr_rd(A_ADDR0, v);
        do_csr_rd(A_DATA0, v);
        do_csr_wr(8'h10, 32'hFFFF_FFFF);
        csr_read(8'h10, v);
        check("unmapped_rd", v, 32'd0);

        // Read on address write, 32-bit
        bus_rdy_dly = 1; bus_rsp_dly = 2; bus_err = 1'b0; bus_rdata = 32'hDEAD_BEEF;
        do_csr_wr(A_SBCS, 32'h0014_0000);
        do_csr_wr(A_ADDR0, 32'h0000_1000);
        do_csr_rd(A_DATA0, v);
        check("rd32_data", v, 32'hDEAD_BEEF);

        // Byte read is zero-extended
        bus_rdata = 32'hCAFE_BABE;
        do_csr_wr(A_SBCS, 32'h0010_0000);
        do_csr_wr(A_ADDR0, 32'h0000_1003);
        do_csr_rd(A_DATA0, v);
        check("rd8_mask", v, 32'h0000_00BE);

        // Autoincrementing writes; address-only write does not start a transfer
        bus_rdy_dly = 0; bus_rsp_dly = 0;
        do_csr_wr(A_SBCS, 32'h0005_0000);
        do_csr_wr(A_ADDR0, 32'h0000_2000);
        check("addr_only_no_req", 32'(sb_req_vld), 32'd0);
        do_csr_wr(A_DATA0, 32'h0000_0011);
        do_csr_wr(A_DATA0, 32'h0000_0022);
        do_csr_wr(A_DATA0, 32'h0000_0033);
        do_csr_rd(A_ADDR0, v);
        check("autoinc_final", v, 32'h0000_200C);

        // Autoincrement wraps at 32 bits
        do_csr_wr(A_SBCS, 32'h0015_0000);
        bus_rdata = 32'h0102_0304;
        do_csr_wr(A_ADDR0, 32'hFFFF_FFFC);
        do_csr_rd(A_ADDR0, v);
        check("autoinc_wrap", v, 32'd0);

        // Accesses while busy set sbbusyerror and leave registers/bus untouched
        do_csr_wr(A_SBCS, 32'h0004_0000);
        do_csr_wr(A_ADDR0, 32'h0000_3000);
        csr_write(A_DATA0, 32'hA5A5_0001);
        m_data = 32'hA5A5_0001;
        check("busy_req_vld", 32'(sb_req_vld), 32'd1);
        csr_write(A_DATA0, 32'h1234_5678);
        m_busyerr = 1'b1;
        csr_read(A_DATA0, v);
        check("busy_rd_data0", v, 32'hA5A5_0001);
        repeat (3) @(negedge clk);
        check("busy_wdata_hold", sb_req_wdata, 32'hA5A5_0001);
        check("busy_addr_hold", sb_req_addr, 32'h0000_3000);
        bus_rdy_dly = 0; bus_rsp_dly = 1;
        serve(1'b1, 32'h0000_3000, 32'hA5A5_0001);
        do_csr_rd(A_SBCS, v);
        check("busyerr_bit", 32'(v[22]), 32'd1);
        do_csr_wr(A_DATA0, 32'h0000_5555);
        do_csr_wr(A_SBCS, 32'h0044_0000);
        do_csr_wr(A_DATA0, 32'h0000_6666);
        do_csr_rd(A_DATA0, v);

        // Trigger-time errors
        do_csr_wr(A_SBCS, 32'h0012_0000);
        do_csr_wr(A_ADDR0, 32'h0000_1001);
        do_csr_rd(A_SBCS, v);
        check("misalign_err", 32'(v[14:12]), 32'd3);
        do_csr_wr(A_SBCS, 32'h0016_7000);
        do_csr_wr(A_ADDR0, 32'h0000_1000);
        do_csr_rd(A_SBCS, v);
        check("badsize_err", 32'(v[14:12]), 32'd4);

        // Bus error on read leaves data unchanged
        do_csr_wr(A_SBCS, 32'h0014_7000);
        saved = m_data;
        bus_err = 1'b1; bus_rdata = 32'h7777_7777;
        do_csr_wr(A_ADDR0, 32'h0000_4000);
        bus_err = 1'b0;
        do_csr_rd(A_DATA0, v);
        check("rsperr_data_kept", v, saved);
        do_csr_rd(A_SBCS, v);
        check("rsperr_err", 32'(v[14:12]), 32'd2);

        // Response error and W1C of the same code in one cycle: set wins
        do_csr_wr(A_SBCS, 32'h0014_7000);
        csr_write(A_ADDR0, 32'h0000_5000);
        m_addr = 32'h0000_5000;
        check("w1c_race_req", 32'(sb_req_vld), 32'd1);
        sb_req_rdy = 1'b1;
        @(negedge clk);
        sb_req_rdy = 1'b0;
        sb_rsp_vld = 1'b1; sb_rsp_err = 1'b1;
        csr_wr_en = 1'b1; csr_addr = A_SBCS; csr_wdata = 32'h0014_2000;
        @(negedge clk);
        sb_rsp_vld = 1'b0; sb_rsp_err = 1'b0; csr_wr_en = 1'b0;
        m_err = 3'd2;
        do_csr_rd(A_SBCS, v);
        check("w1c_race_err", 32'(v[14:12]), 32'd2);

        // Response timeout (or indefinite wait when the timeout is not built in)
        do_csr_wr(A_SBCS, 32'h0014_7000);
        csr_write(A_ADDR0, 32'h0000_6000);
        m_addr = 32'h0000_6000;
        check("tmo_req", 32'(sb_req_vld), 32'd1);
        sb_req_rdy = 1'b1;
        @(negedge clk);
        sb_req_rdy = 1'b0;
`ifdef SBA_TIMEOUT_EN
        cyc = 0;
        still_busy = 1'b1;
        while (still_busy && cyc < int'(TMO) + 20) begin
            csr_read(A_SBCS, v);
            still_busy = v[21];
            cyc++;
        end
        check("tmo_cycles", 32'(cyc >= int'(TMO) - 2 && cyc <= int'(TMO) + 2), 32'd1);
        m_err = 3'd1;
        do_csr_rd(A_SBCS, v);
        do_csr_rd(A_ADDR0, v);
`else
        cyc = 0;
        still_busy = 1'b1;
        repeat (TMO + 20) @(negedge clk);
        csr_read(A_SBCS, v);
        still_busy = v[21];
        check("no_tmo_busy", 32'(still_busy), 32'd1);
        check("no_tmo_err", 32'(v[14:12]), 32'd0);
        sb_rsp_vld = 1'b1; sb_rsp_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        sb_rsp_vld = 1'b0;
        m_data = 32'h0BAD_F00D;
        do_csr_rd(A_SBCS, v);
        do_csr_rd(A_DATA0, v);
`endif

        // Reset while waiting for a response; late response is ignored
        do_csr_wr(A_SBCS, 32'h0014_7000);
        csr_write(A_ADDR0, 32'h0000_7000);
        sb_req_rdy = 1'b1;
        @(negedge clk);
        sb_req_rdy = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb_rsp_vld = 1'b1; sb_rsp_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        sb_rsp_vld = 1'b0;
        model_reset();
        check("rst_mid_vld", 32'(sb_req_vld), 32'd0);
        csr_read(A_SBCS, v);
        check("rst_mid_sbcs", v, SBCS_RESET);
        csr_read(A_DATA0, v);
        check("rst_mid_data", v, 32'd0);

        // Randomized CSR traffic against the model
        for (int it = 0; it < 300; it++) begin
            int op;
            op = $urandom_range(0, 7);
            bus_rdy_dly = $urandom_range(0, 3);
            bus_rsp_dly = $urandom_range(0, 3);
            bus_err     = ($urandom_range(0, 7) == 0);
            bus_rdata   = $urandom;
            case (op)
                0: begin
                    d = $urandom;
                    d[19:17] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                                          : 3'($urandom_range(0, 2));
                    do_csr_wr(A_SBCS, d);
                end
                1: begin
                    d = $urandom;
                    if ($urandom_range(0, 3) != 0) d[1:0] = 2'b00;
                    do_csr_wr(A_ADDR0, d);
                end
                2: do_csr_wr(A_DATA0, $urandom);
                3: do_csr_rd(A_DATA0, v);
                4: do_csr_rd(A_SBCS, v);
                5: do_csr_rd(A_ADDR0, v);
                6: begin
                    a = 8'($urandom_range(0, 255));
                    if (a == A_SBCS || a == A_ADDR0 || a == A_DATA0) a = 8'h00;
                    do_csr_wr(a, $urandom);
                    do_csr_rd(a, v);
                end
                default: begin
                    d = $urandom;
                    d[22] = 1'b1;
                    d[14:12] = 3'b111;
                    d[19:17] = 3'($urandom_range(0, 2));
                    do_csr_wr(A_SBCS, d);
                end
            endcase
        end
        do_csr_rd(A_SBCS, v);
        do_csr_rd(A_ADDR0, v);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
